// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch stage for the prco core.
// Owns the PC, issues one-cycle fetch strobes to local memory, captures the
// returned word into the instruction register and hands it to decode with a
// valid/ready handshake. Handles branch redirects, data-side memory
// back-pressure, fetch timeouts and a sticky halt.
module prco_fetch #(
   parameter logic [15:0] P_RESET_VECTOR = 16'h0000,
   parameter logic [15:0] P_ADDR_MAX     = 16'h00FF,
   parameter logic [3:0]  P_WAIT_TIMEOUT = 4'd15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_run,
   input  logic        i_halt,
   input  logic        i_mem_busy,
   output logic        q_ce_fetch,
   output logic [15:0] q_fetch_addr,
   input  logic        i_mem_ce_dec,
   input  logic [15:0] i_mem_data,
   output logic [15:0] q_ir,
   output logic [15:0] q_ir_pc,
   output logic        q_ir_valid,
   input  logic        i_ir_ready,
   input  logic        i_branch,
   input  logic [15:0] i_branch_target,
   output logic [15:0] q_pc,
   output logic        q_halted,
   output logic        q_fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DROP  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] ir_q;
   logic [15:0] ir_pc_q;
   logic        ir_valid_q;
   logic        halted_q;
   logic        fetch_err_q;
   logic        halt_pend_q;
   logic [3:0]  wait_cnt_q;

   logic        halt_now;
   logic        handshake;
   logic        strobe;
   logic        timeout;
   logic        in_flight;
   logic [3:0]  wait_cnt_d;
   logic [15:0] pc_inc_d;
   logic [15:0] pc_branch_d;

   // A halt request seen this cycle acts immediately, as if already pending.
   assign halt_now    = halt_pend_q | i_halt;
   assign handshake   = ir_valid_q & i_ir_ready;
   assign in_flight   = (state_q == S_WAIT) || (state_q == S_DROP);

   // The strobe has to react to busy/branch/halt in the same cycle, so it is
   // decoded from the state rather than registered; it only exists in ISSUE,
   // which always leaves after one strobe, so it can never be high twice in a row.
   assign strobe      = (state_q == S_ISSUE) && !i_mem_busy && !i_branch && !halt_now;

   // Counter saturates so a redirect arriving late in DROP cannot wrap it.
   assign wait_cnt_d  = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
   assign timeout     = ({1'b0, wait_cnt_q} + 5'd1) >= {1'b0, P_WAIT_TIMEOUT};
   assign pc_inc_d    = (pc_q == P_ADDR_MAX) ? 16'h0000 : pc_q + 16'd1;
   assign pc_branch_d = i_branch_target & P_ADDR_MAX;

   assign q_ce_fetch   = strobe;
   assign q_fetch_addr = strobe ? pc_q : 16'h0000;
   assign q_ir         = ir_q;
   assign q_ir_pc      = ir_pc_q;
   assign q_ir_valid   = ir_valid_q;
   assign q_pc         = pc_q;
   assign q_halted     = halted_q;
   assign q_fetch_err  = fetch_err_q;

   // Fetch FSM: PC, instruction register, wait counter and sticky flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         pc_q        <= P_RESET_VECTOR;
         ir_q        <= 16'h0000;
         ir_pc_q     <= 16'h0000;
         ir_valid_q  <= 1'b0;
         halted_q    <= 1'b0;
         fetch_err_q <= 1'b0;
         halt_pend_q <= 1'b0;
         wait_cnt_q  <= 4'd0;
      end else if (state_q == S_HALT) begin
         // Terminal until reset: run, branch and memory responses are ignored.
         halted_q <= 1'b1;
      end else begin
         if (i_halt)
            halt_pend_q <= 1'b1;

         if (i_branch) begin
            // Redirect wins; any word on offer (held or in flight) is wrong-path.
            pc_q       <= pc_branch_d;
            ir_valid_q <= 1'b0;
            if (in_flight) begin
               // The outstanding strobe must still be drained before reissuing.
               state_q    <= S_DROP;
               wait_cnt_q <= wait_cnt_d;
            end else begin
               state_q <= S_ISSUE;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (halt_now) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end else if (i_run) begin
                     state_q <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (halt_now) begin
                     // Nothing issued yet, so nothing to wait for.
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end else if (!i_mem_busy) begin
                     wait_cnt_q <= 4'd0;
                     state_q    <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (i_mem_ce_dec) begin
                     ir_q       <= i_mem_data;
                     ir_pc_q    <= pc_q;
                     ir_valid_q <= 1'b1;
                     pc_q       <= pc_inc_d;
                     state_q    <= S_HOLD;
                  end else if (timeout) begin
                     // PC untouched: the same address is fetched again.
                     fetch_err_q <= 1'b1;
                     state_q     <= S_ISSUE;
                  end else begin
                     wait_cnt_q <= wait_cnt_d;
                  end
               end
               S_HOLD: begin
                  if (handshake) begin
                     ir_valid_q <= 1'b0;
                     if (halt_now) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                     end else if (!i_run) begin
                        state_q <= S_IDLE;
                     end else begin
                        state_q <= S_ISSUE;
                     end
                  end
               end
               S_DROP: begin
                  // Wrong-path word or expiry: discard quietly and refetch.
                  if (i_mem_ce_dec || timeout)
                     state_q <= S_ISSUE;
                  else
                     wait_cnt_q <= wait_cnt_d;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prco_fetch.sv
// Self-checking bench for prco_fetch: directed scenarios followed by a
// randomized run, every cycle compared against a flag-based behavioural model.
module tb_prco_fetch;

   localparam logic [15:0] ADDR_MAX = 16'h00FF;
   localparam int          TMO      = 15;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_run = 1'b0;
   logic        i_halt = 1'b0;
   logic        i_mem_busy = 1'b0;
   logic        i_mem_ce_dec = 1'b0;
   logic [15:0] i_mem_data = 16'h0000;
   logic        i_ir_ready = 1'b0;
   logic        i_branch = 1'b0;
   logic [15:0] i_branch_target = 16'h0000;
   logic        q_ce_fetch, q_ir_valid, q_halted, q_fetch_err;
   logic [15:0] q_fetch_addr, q_ir, q_ir_pc, q_pc;

   prco_fetch dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_run           (i_run),
      .i_halt          (i_halt),
      .i_mem_busy      (i_mem_busy),
      .q_ce_fetch      (q_ce_fetch),
      .q_fetch_addr    (q_fetch_addr),
      .i_mem_ce_dec    (i_mem_ce_dec),
      .i_mem_data      (i_mem_data),
      .q_ir            (q_ir),
      .q_ir_pc         (q_ir_pc),
      .q_ir_valid      (q_ir_valid),
      .i_ir_ready      (i_ir_ready),
      .i_branch        (i_branch),
      .i_branch_target (i_branch_target),
      .q_pc            (q_pc),
      .q_halted        (q_halted),
      .q_fetch_err     (q_fetch_err)
   );

   always #5 i_clk = ~i_clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [15:0] mem [256];
   bit          deaf = 1'b0;
   bit          rnd = 1'b0;
   int          s_cyc[$];
   logic [15:0] s_addr[$];
   logic [15:0] c_ir[$];
   logic [15:0] c_pc[$];
   logic [15:0] c_nxt[$];
   logic        prev_valid = 1'b0;

   // Reference model: the stage is described by what it is doing, not by a state code.
   logic [15:0] m_pc, m_ir, m_ir_pc;
   bit          m_valid, m_halted, m_err, m_hpend;
   bit          m_want;   // waiting for a chance to strobe
   bit          m_fly;    // a strobe is outstanding
   bit          m_junk;   // the outstanding strobe is on a discarded path
   int          m_age;    // cycles spent waiting on the outstanding strobe

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_ir = 16'h0000; m_ir_pc = 16'h0000;
      m_valid = 0; m_halted = 0; m_err = 0; m_hpend = 0;
      m_want = 0; m_fly = 0; m_junk = 0; m_age = 0;
   endtask

   task automatic model_step();
      bit hp;
      if (i_reset) begin
         model_reset();
         return;
      end
      if (m_halted) return;
      hp = m_hpend || i_halt;
      if (i_halt) m_hpend = 1;
      if (i_branch) begin
         m_pc    = i_branch_target & ADDR_MAX;
         m_valid = 0;
         if (m_fly) begin
            m_junk = 1;
            m_age  = (m_age + 1 > 15) ? 15 : m_age + 1;
         end else begin
            m_want = 1;
         end
         return;
      end
      if (m_fly) begin
         if (i_mem_ce_dec) begin
            m_fly = 0;
            if (m_junk) begin
               m_junk = 0;
               m_want = 1;
            end else begin
               m_ir    = i_mem_data;
               m_ir_pc = m_pc;
               m_valid = 1;
               m_pc    = (m_pc == ADDR_MAX) ? 16'h0000 : m_pc + 16'd1;
            end
         end else if (m_age + 1 >= TMO) begin
            m_fly  = 0;
            m_want = 1;
            if (!m_junk) m_err = 1;
            m_junk = 0;
         end else begin
            m_age = (m_age + 1 > 15) ? 15 : m_age + 1;
         end
      end else if (m_valid) begin
         if (i_ir_ready) begin
            m_valid = 0;
            if (hp) m_halted = 1;
            else if (i_run) m_want = 1;
         end
      end else if (hp && (m_want || 1'b1)) begin
         m_halted = 1;
         m_want   = 0;
      end else if (m_want && !i_mem_busy) begin
         m_want = 0;
         m_fly  = 1;
         m_age  = 0;
      end else if (i_run) begin
         m_want = 1;
      end
   endtask

   // One clock: compare all outputs, log strobes/captures, advance the model,
   // then present the memory's registered response for the next cycle.
   task automatic tick();
      bit          exp_ce;
      bit          seen_ce;
      logic [15:0] seen_addr;
      #1;
      exp_ce = m_want && !m_halted && !i_mem_busy && !i_branch && !(m_hpend || i_halt);
      chk("ce",     32'(q_ce_fetch),   32'(exp_ce));
      chk("faddr",  32'(q_fetch_addr), 32'(exp_ce ? m_pc : 16'h0000));
      chk("pc",     32'(q_pc),         32'(m_pc));
      chk("ir",     32'(q_ir),         32'(m_ir));
      chk("ir_pc",  32'(q_ir_pc),      32'(m_ir_pc));
      chk("valid",  32'(q_ir_valid),   32'(m_valid));
      chk("halted", 32'(q_halted),     32'(m_halted));
      chk("err",    32'(q_fetch_err),  32'(m_err));
      seen_ce   = q_ce_fetch;
      seen_addr = q_fetch_addr;
      if (seen_ce) begin
         s_cyc.push_back(cyc);
         s_addr.push_back(seen_addr);
      end
      if (q_ir_valid && !prev_valid) begin
         c_ir.push_back(q_ir);
         c_pc.push_back(q_ir_pc);
         c_nxt.push_back(q_pc);
      end
      prev_valid = q_ir_valid;
      @(posedge i_clk);
      model_step();
      cyc++;
      @(negedge i_clk);
      if (seen_ce && !deaf && !(rnd && $urandom_range(0, 9) == 0)) begin
         i_mem_ce_dec = 1'b1;
         i_mem_data   = mem[seen_addr[7:0]];
      end else if (rnd && $urandom_range(0, 19) == 0) begin
         i_mem_ce_dec = 1'b1;
         i_mem_data   = 16'($urandom);
      end else begin
         i_mem_ce_dec = 1'b0;
         i_mem_data   = 16'($urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, nc, n, bf, hs;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h00] = 16'h2002;
      mem[8'h01] = 16'h2102;
      mem[8'hAA] = 16'h00CA;
      model_reset();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      cyc = 0;

      // Reset state
      chk("rst_pc",    32'(q_pc),         32'h0);
      chk("rst_ce",    32'(q_ce_fetch),   32'h0);
      chk("rst_faddr", 32'(q_fetch_addr), 32'h0);
      chk("rst_ir",    32'(q_ir),         32'h0);
      chk("rst_valid", 32'(q_ir_valid),   32'h0);
      chk("rst_halt",  32'(q_halted),     32'h0);
      chk("rst_err",   32'(q_fetch_err),  32'h0);

      // Straight-line fetch of two words
      i_run = 1'b1;
      i_ir_ready = 1'b1;
      repeat (6) tick();
      chk("t1_ir",     32'(q_ir),    32'h2102);
      chk("t1_irpc",   32'(q_ir_pc), 32'h0001);
      chk("t1_pc",     32'(q_pc),    32'h0002);
      chk("t1_ns",     32'(s_cyc.size()), 32'd2);
      chk("t1_s0cyc",  32'((s_cyc.size() > 0) ? s_cyc[0] : -1), 32'd1);
      chk("t1_s0addr", 32'((s_addr.size() > 0) ? s_addr[0] : 16'hFFFF), 32'h0000);
      chk("t1_s1cyc",  32'((s_cyc.size() > 1) ? s_cyc[1] : -1), 32'd4);
      chk("t1_s1addr", 32'((s_addr.size() > 1) ? s_addr[1] : 16'hFFFF), 32'h0001);
      chk("t1_c0ir",   32'((c_ir.size() > 0) ? c_ir[0] : 16'hFFFF), 32'h2002);
      chk("t1_c0pc",   32'((c_pc.size() > 0) ? c_pc[0] : 16'hFFFF), 32'h0000);

      // Decode stalls: word held, no further strobe
      i_ir_ready = 1'b0;
      repeat (5) begin
         tick();
         chk("t2_valid", 32'(q_ir_valid), 32'h1);
         chk("t2_ir",    32'(q_ir),       32'h2102);
      end
      chk("t2_nostrobe", 32'(s_cyc.size()), 32'd2);
      i_ir_ready = 1'b1;
      hs = cyc;
      tick();
      tick();
      chk("t2_ns",    32'(s_cyc.size()), 32'd3);
      chk("t2_scyc",  32'((s_cyc.size() > 2) ? s_cyc[2] : -1), 32'(hs + 1));
      chk("t2_saddr", 32'((s_addr.size() > 2) ? s_addr[2] : 16'hFFFF), 32'h0002);

      // Data-side busy while ready to strobe
      n = 0;
      while (!m_want && n < 20) begin tick(); n++; end
      chk("t3_reach", 32'(m_want), 32'h1);
      i_mem_busy = 1'b1;
      ns = s_cyc.size();
      repeat (4) tick();
      chk("t3_nostrobe", 32'(s_cyc.size()), 32'(ns));
      i_mem_busy = 1'b0;
      bf = cyc;
      tick();
      chk("t3_ns",    32'(s_cyc.size()), 32'(ns + 1));
      chk("t3_scyc",  32'((s_cyc.size() > 0) ? s_cyc[$] : -1), 32'(bf));
      chk("t3_saddr", 32'((s_addr.size() > 0) ? s_addr[$] : 16'hFFFF), 32'h0003);

      // Branch during WAIT: in-flight word dropped, target masked
      n = 0;
      while (!(m_fly && !m_junk) && n < 20) begin tick(); n++; end
      chk("t4_reach", 32'(m_fly), 32'h1);
      i_branch = 1'b1;
      i_branch_target = 16'h01AA;
      ns = s_cyc.size();
      nc = c_ir.size();
      tick();
      i_branch = 1'b0;
      chk("t4_valid", 32'(q_ir_valid), 32'h0);
      chk("t4_pc",    32'(q_pc),       32'h00AA);
      n = 0;
      while (c_ir.size() <= nc && n < 60) begin tick(); n++; end
      chk("t4_cap",   32'(c_ir.size()), 32'(nc + 1));
      chk("t4_ir",    32'((c_ir.size() > nc) ? c_ir[nc] : 16'hFFFF), 32'h00CA);
      chk("t4_irpc",  32'((c_pc.size() > nc) ? c_pc[nc] : 16'hFFFF), 32'h00AA);
      chk("t4_saddr", 32'((s_addr.size() > ns) ? s_addr[ns] : 16'hFFFF), 32'h00AA);

      // PC wrap at the top of the address space
      i_branch = 1'b1;
      i_branch_target = 16'h12FF;
      nc = c_ir.size();
      tick();
      i_branch = 1'b0;
      n = 0;
      while (c_ir.size() <= nc && n < 40) begin tick(); n++; end
      chk("t5_irpc", 32'((c_pc.size() > nc) ? c_pc[nc] : 16'h0000), 32'h00FF);
      chk("t5_ir",   32'((c_ir.size() > nc) ? c_ir[nc] : ~mem[8'hFF]), 32'(mem[8'hFF]));
      chk("t5_pc",   32'((c_nxt.size() > nc) ? c_nxt[nc] : 16'hFFFF), 32'h0000);
      ns = s_cyc.size();
      n = 0;
      while (s_cyc.size() <= ns && n < 20) begin tick(); n++; end
      chk("t5_saddr", 32'((s_addr.size() > ns) ? s_addr[ns] : 16'hFFFF), 32'h0000);

      // Memory never answers: timeout and re-strobe of the same address
      deaf = 1'b1;
      ns = s_cyc.size();
      n = 0;
      while (s_cyc.size() <= ns + 1 && n < 60) begin tick(); n++; end
      chk("t6_gap",  32'((s_cyc.size() > ns + 1) ? s_cyc[ns+1] - s_cyc[ns] : -1), 32'd16);
      chk("t6_addr", 32'((s_addr.size() > ns + 1) ? s_addr[ns+1] : 16'hFFFF),
                     32'((s_addr.size() > ns) ? s_addr[ns] : 16'h0000));
      chk("t6_err",  32'(q_fetch_err), 32'h1);
      deaf = 1'b0;

      // Halt while holding a word: halts after the handshake, then stays quiet
      n = 0;
      while (!m_valid && n < 60) begin tick(); n++; end
      chk("t7_reach", 32'(q_ir_valid), 32'h1);
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      chk("t7_halted", 32'(q_halted), 32'h1);
      ns = s_cyc.size();
      i_branch = 1'b1;
      i_branch_target = 16'h0010;
      tick();
      i_branch = 1'b0;
      repeat (9) tick();
      chk("t7_nostrobe", 32'(s_cyc.size()), 32'(ns));
      chk("t7_sticky",   32'(q_halted), 32'h1);

      // Only reset leaves HALT
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      chk("t8_halted", 32'(q_halted),    32'h0);
      chk("t8_err",    32'(q_fetch_err), 32'h0);
      chk("t8_pc",     32'(q_pc),        32'h0);

      // Randomized run against the model
      rnd = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         i_reset         = ($urandom_range(0, 299) == 0);
         i_run           = ($urandom_range(0, 7) != 0);
         i_halt          = ($urandom_range(0, 599) == 0);
         i_mem_busy      = ($urandom_range(0, 3) == 0);
         i_ir_ready      = ($urandom_range(0, 1) == 1);
         i_branch        = ($urandom_range(0, 15) == 0);
         i_branch_target = 16'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
